// File: rtl/butterfly_pkg.sv
// Shared types for the fetch/LSU memory arbiter: FSM states and transaction owner.
package butterfly_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between fetch and LSU requests.
// ARB_ROUND_ROBIN_EN: on contention the requester not granted last wins; otherwise LSU wins.
module arb_pick
  import butterfly_pkg::*;
(
  input  logic       if_req,
  input  logic       lsu_req,
  input  arb_owner_e last_win,
  output arb_owner_e winner
);

  always_comb begin
    winner = OWNER_IF;
    if (if_req && lsu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_win == OWNER_LSU) ? OWNER_IF : OWNER_LSU;
`else
      winner = OWNER_LSU;
`endif
    end else if (lsu_req) begin
      winner = OWNER_LSU;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the history input.
  logic unused_last_win;
  assign unused_last_win = (last_win == OWNER_LSU);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and LSU, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of LSU-priority arbitration.
module mem_arbiter
  import butterfly_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [3:0]        lsu_be_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              proto_err_o
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, winner, last_win;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              proto_err_q;
  logic              grant;
  logic              rsp_unexpected;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e last_q;
  assign last_win = last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWNER_IF;
    end else if (grant) begin
      last_q <= winner;
    end
  end
`else
  assign last_win = OWNER_IF;
`endif

  arb_pick u_pick (
    .if_req   (if_req_i),
    .lsu_req  (lsu_req_i),
    .last_win (last_win),
    .winner   (winner)
  );

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (if_req_i || lsu_req_i) begin
          grant   = 1'b1;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_LSU) begin
            lsu_rvalid_o = 1'b1;
            lsu_rdata_o  = mem_rdata_i;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grants are combinational from the request, so hold them low while reset is asserted.
  assign if_gnt_o       = grant && rst_ni && (winner == OWNER_IF);
  assign lsu_gnt_o      = grant && rst_ni && (winner == OWNER_LSU);
  assign rsp_unexpected = mem_rvalid_i && (state_q != ARB_WAIT);
  assign proto_err_o    = proto_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rsp_unexpected) proto_err_q <= 1'b1;
      if (grant) begin
        owner_q <= winner;
        if (winner == OWNER_LSU) begin
          addr_q  <= lsu_addr_i;
          we_q    <= lsu_we_i;
          be_q    <= lsu_be_i;
          wdata_q <= lsu_wdata_i;
        end else begin
          addr_q  <= if_addr_i;
          we_q    <= 1'b0;
          be_q    <= FETCH_BE;
          wdata_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences, randomized model check.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic        clk, rst_ni;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, proto_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req, lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct {
    logic        if_gnt, lsu_gnt, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        proto_err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[12];

  function automatic in_t mk_in(logic ir, logic [31:0] ia, logic lr, logic lw, logic [3:0] lb,
                                logic [31:0] la, logic [31:0] ld, logic mg, logic mv, logic [31:0] md);
    in_t x;
    x.if_req = ir; x.if_addr = ia; x.lsu_req = lr; x.lsu_we = lw; x.lsu_be = lb;
    x.lsu_addr = la; x.lsu_wdata = ld; x.mem_gnt = mg; x.mem_rvalid = mv; x.mem_rdata = md;
    return x;
  endfunction

  function automatic exp_t mk_ex(logic ig, logic lg, logic mr, logic mw, logic [3:0] mb,
                                 logic [31:0] ma, logic [31:0] md, logic iv, logic [31:0] id,
                                 logic lv, logic [31:0] ld, logic pe);
    exp_t x;
    x.if_gnt = ig; x.lsu_gnt = lg; x.mem_req = mr; x.mem_we = mw; x.mem_be = mb;
    x.mem_addr = ma; x.mem_wdata = md; x.if_rvalid = iv; x.if_rdata = id;
    x.lsu_rvalid = lv; x.lsu_rdata = ld; x.proto_err = pe;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk1({tag, " if_gnt"}, if_gnt_o, e.if_gnt);
    chk1({tag, " lsu_gnt"}, lsu_gnt_o, e.lsu_gnt);
    chk1({tag, " mem_req"}, mem_req_o, e.mem_req);
    chk1({tag, " mem_we"}, mem_we_o, e.mem_we);
    chk({tag, " mem_be"}, 32'(mem_be_o), 32'(e.mem_be));
    chk({tag, " mem_addr"}, mem_addr_o, e.mem_addr);
    chk({tag, " mem_wdata"}, mem_wdata_o, e.mem_wdata);
    chk1({tag, " if_rvalid"}, if_rvalid_o, e.if_rvalid);
    chk({tag, " if_rdata"}, if_rdata_o, e.if_rdata);
    chk1({tag, " lsu_rvalid"}, lsu_rvalid_o, e.lsu_rvalid);
    chk({tag, " lsu_rdata"}, lsu_rdata_o, e.lsu_rdata);
    chk1({tag, " proto_err"}, proto_err_o, e.proto_err);
  endtask

  task automatic apply_in(input in_t x);
    if_req_i = x.if_req; if_addr_i = x.if_addr; lsu_req_i = x.lsu_req; lsu_we_i = x.lsu_we;
    lsu_be_i = x.lsu_be; lsu_addr_i = x.lsu_addr; lsu_wdata_i = x.lsu_wdata;
    mem_gnt_i = x.mem_gnt; mem_rvalid_i = x.mem_rvalid; mem_rdata_i = x.mem_rdata;
  endtask

  task automatic idle_inputs();
    apply_in(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // One full transaction with minimum latency; requests are already driven by the caller.
  task automatic txn(input bit exp_lsu, input string tag, input logic [31:0] rd);
    logic [31:0] exp_addr;
    exp_addr = exp_lsu ? lsu_addr_i : if_addr_i;
    @(negedge clk);
    chk1({tag, " if_gnt"}, if_gnt_o, !exp_lsu);
    chk1({tag, " lsu_gnt"}, lsu_gnt_o, exp_lsu);
    next_cycle();
    mem_gnt_i = 1'b1;
    @(negedge clk);
    chk1({tag, " mem_req"}, mem_req_o, 1'b1);
    chk({tag, " mem_addr"}, mem_addr_o, exp_addr);
    next_cycle();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rd;
    @(negedge clk);
    chk1({tag, " if_rvalid"}, if_rvalid_o, !exp_lsu);
    chk1({tag, " lsu_rvalid"}, lsu_rvalid_o, exp_lsu);
    next_cycle();
    mem_rvalid_i = 1'b0;
  endtask

  // Transaction-level reference: at most one pending transaction, tracked as a record.
  bit          m_busy, m_acc, m_owner_lsu, m_last_lsu, m_err, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  function automatic bit pick_lsu(bit r_if, bit r_lsu, bit last_lsu);
    if (r_if && r_lsu) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_lsu;
`else
      return 1'b1;
`endif
    end
    return r_lsu;
  endfunction

  task automatic model_step(output exp_t e);
    bit w;
    e = mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_err);
    w = pick_lsu(if_req_i, lsu_req_i, m_last_lsu);
    if (!m_busy) begin
      if (if_req_i || lsu_req_i) begin
        e.if_gnt = !w; e.lsu_gnt = w;
      end
    end else if (!m_acc) begin
      e.mem_req = 1; e.mem_we = m_we; e.mem_be = m_be; e.mem_addr = m_addr; e.mem_wdata = m_wdata;
    end else if (mem_rvalid_i) begin
      if (m_owner_lsu) begin e.lsu_rvalid = 1; e.lsu_rdata = mem_rdata_i; end
      else begin e.if_rvalid = 1; e.if_rdata = mem_rdata_i; end
    end
    if (mem_rvalid_i && !(m_busy && m_acc)) m_err = 1;
    if (!m_busy) begin
      if (if_req_i || lsu_req_i) begin
        m_busy = 1; m_acc = 0; m_owner_lsu = w; m_last_lsu = w;
        m_addr  = w ? lsu_addr_i : if_addr_i;
        m_we    = w ? lsu_we_i : 1'b0;
        m_be    = w ? lsu_be_i : 4'hF;
        m_wdata = w ? lsu_wdata_i : 32'h0;
      end
    end else if (!m_acc) begin
      if (mem_gnt_i) m_acc = 1;
    end else if (mem_rvalid_i) begin
      m_busy = 0;
    end
  endtask

  initial begin
    exp_t e;
    bit   rr;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    tbl[0]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                mk_ex(0, 0, 1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13),
                mk_ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0)};
    tbl[3]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{mk_in(1, 32'h300, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0, 0),
                mk_ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{mk_in(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0),
                mk_ex(0, 0, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, 0)};
    tbl[6]  = '{mk_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h55),
                mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0)};
    tbl[7]  = '{mk_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_ex(0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                mk_ex(0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234),
                mk_ex(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 0)};
    tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    do_reset();
    @(negedge clk);
    chk_all("reset", mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();

    for (int k = 0; k < 12; k++) begin
      apply_in(tbl[k].i);
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), tbl[k].e);
      next_cycle();
    end

    // Memory stalls grant for 5 cycles; latched fields must not follow the live inputs.
    lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'h5; lsu_addr_i = 32'h600; lsu_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk1("stall grant", lsu_gnt_o, 1'b1);
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h640; lsu_addr_i = 32'h700; lsu_wdata_i = 32'h0; lsu_be_i = 4'hA;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_all($sformatf("stall%0d", k),
              mk_ex(0, 0, 1, 1, 4'h5, 32'h600, 32'hCAFEF00D, 0, 0, 0, 0, 0));
      next_cycle();
    end
    mem_gnt_i = 1;
    @(negedge clk);
    chk1("stall accept mem_req", mem_req_o, 1'b1);
    next_cycle();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77; if_req_i = 0; lsu_req_i = 0;
    @(negedge clk);
    chk1("stall ack", lsu_rvalid_o, 1'b1);
    next_cycle();
    idle_inputs();

    // Contention right after an LSU grant separates the two arbitration policies.
    lsu_req_i = 1; lsu_addr_i = 32'h400; lsu_we_i = 0; lsu_be_i = 4'hF;
    txn(1'b1, "lsu_only", 32'h11);
    if_req_i = 1; if_addr_i = 32'h500;
    txn(!rr, "contend1", 32'h22);
    txn(1'b1, "contend2", 32'h33);
    idle_inputs();

    // Stray response in IDLE sets a sticky error and delivers nothing.
    @(negedge clk);
    chk1("perr before", proto_err_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
    @(negedge clk);
    chk1("stray if_rvalid", if_rvalid_o, 1'b0);
    chk1("stray lsu_rvalid", lsu_rvalid_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk1("perr set", proto_err_o, 1'b1);
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h900;
    txn(1'b0, "after_err", 32'h44);
    idle_inputs();
    @(negedge clk);
    chk1("perr sticky", proto_err_o, 1'b1);
    next_cycle();
    rst_ni = 0;
    #1;
    chk1("perr cleared", proto_err_o, 1'b0);
    next_cycle();
    rst_ni = 1;
    next_cycle();

    // Reset while waiting for the response: outputs drop at once, late response is stray.
    lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h800;
    @(negedge clk);
    chk1("midrst grant", lsu_gnt_o, 1'b1);
    next_cycle();
    lsu_req_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    chk1("midrst mem_req", mem_req_o, 1'b1);
    next_cycle();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5; if_req_i = 1; lsu_req_i = 1;
    #1;
    chk1("midrst pre rvalid", lsu_rvalid_o, 1'b1);
    rst_ni = 0;
    #1;
    chk_all("midrst in reset", mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle_inputs();
    next_cycle();
    rst_ni = 1;
    next_cycle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h5A5A;
    @(negedge clk);
    chk1("late lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk1("late if_rvalid", if_rvalid_o, 1'b0);
    next_cycle();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk1("late perr", proto_err_o, 1'b1);
    next_cycle();

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_busy = 0; m_acc = 0; m_owner_lsu = 0; m_last_lsu = 0; m_err = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    for (int c = 0; c < 600; c++) begin
      if_req_i     = ($urandom_range(0, 2) != 0);
      if_addr_i    = $urandom;
      lsu_req_i    = ($urandom_range(0, 1) != 0);
      lsu_we_i     = $urandom_range(0, 1) != 0;
      lsu_be_i     = 4'($urandom);
      lsu_addr_i   = $urandom;
      lsu_wdata_i  = $urandom;
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = m_busy && m_acc && ($urandom_range(0, 1) != 0);
      mem_rdata_i  = $urandom;
      @(negedge clk);
      model_step(e);
      chk_all($sformatf("rand%0d", c), e);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
